// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_RTYPE_WB = 4'd7,
        S_BEQ_EX   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_IMM_WB   = 4'd10,
        S_J_EX     = 4'd11,
        S_LOGI_EX  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGI  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_we;
        logic       pc_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alusrc_a;
        logic [1:0] alusrc_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_sel;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decoder for the multi-cycle MIPS FSM.
// LOGIC_IMM_EN adds the LOGI_EX decode (zero-extended immediate, logic ALU op).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req  = 1'b1;
                ctrl.alusrc_b = ALUB_FOUR;
                ctrl.alu_op   = ALUOP_ADD;
                ctrl.pc_src   = PCSRC_ALU;
                ctrl.ir_we    = mem_ready;
                ctrl.pc_we    = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrc_b = ALUB_IMM_SH2;
                ctrl.alu_op   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_IMM;
                ctrl.alu_op   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_RT;
                ctrl.alu_op   = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_RT;
                ctrl.alu_op   = ALUOP_SUB;
                ctrl.pc_src   = PCSRC_ALUOUT;
                ctrl.pc_we    = zero;
            end
            S_ADDI_EX: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_IMM;
                ctrl.alu_op   = ALUOP_ADD;
            end
            S_IMM_WB: begin
                ctrl.reg_we = 1'b1;
            end
            S_J_EX: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_we  = 1'b1;
            end
`ifdef LOGIC_IMM_EN
            S_LOGI_EX: begin
                ctrl.alusrc_a = 1'b1;
                ctrl.alusrc_b = ALUB_IMM;
                ctrl.ext_sel  = 1'b1;
                ctrl.alu_op   = ALUOP_LOGI;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath with memory request/ready stalls.
// Build option LOGIC_IMM_EN enables andi/ori through LOGI_EX; otherwise they decode as illegal.
//
// state     | meaning
// FETCH     | read instruction at PC, PC += 4 when memory answers
// DECODE    | register read, branch target precompute, opcode dispatch
// MEMADR    | load/store effective address
// MEMRD     | load data read, waits on mem_ready
// MEMWB     | load data to rt
// MEMWR     | store data write, waits on mem_ready
// RTYPE_EX  | ALU op selected by funct
// RTYPE_WB  | ALU result to rd
// BEQ_EX    | compare, take branch on zero
// ADDI_EX   | rs + sign-extended immediate
// IMM_WB    | immediate-op result to rt
// J_EX      | jump target to PC
// LOGI_EX   | rs and/or zero-extended immediate
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alusrc_a,
    output logic [1:0]       alusrc_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             ext_sel,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl;
    logic             retire;
    logic             bad_op;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPE_EX;
                    OP_BEQ:       state_d = S_BEQ_EX;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_J_EX;
`ifdef LOGIC_IMM_EN
                    OP_ANDI, OP_ORI: state_d = S_LOGI_EX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_IMM_WB;
            S_IMM_WB:   state_d = S_FETCH;
            S_J_EX:     state_d = S_FETCH;
`ifdef LOGIC_IMM_EN
            S_LOGI_EX:  state_d = S_IMM_WB;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // DECODE falling straight back to FETCH is the only illegal-opcode path.
    assign bad_op = (state_q == S_DECODE) && (state_d == S_FETCH);
    assign retire = (state_q != S_FETCH) && (state_q != S_DECODE) && (state_d == S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= bad_op;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    mips_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    // Reset parks the FSM in FETCH; keep the bus quiet until it is released.
    assign mem_req    = ctrl.mem_req & ~reset;
    assign ir_we      = ctrl.ir_we   & ~reset;
    assign pc_we      = ctrl.pc_we   & ~reset;
    assign mem_we     = ctrl.mem_we;
    assign iord       = ctrl.iord;
    assign reg_we     = ctrl.reg_we;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alusrc_a   = ctrl.alusrc_a;
    assign alusrc_b   = ctrl.alusrc_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_src     = ctrl.pc_src;
    assign ext_sel    = ctrl.ext_sel;
    assign illegal    = illegal_q;
    assign state      = state_q;
    assign instr_cnt  = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction-level reference model with random memory stalls.
module tb_mips_multicycle_ctrl;

    localparam int CW = 4;

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMRD = 3, ST_MEMWB = 4,
                   ST_MEMWR = 5, ST_RTYPE_EX = 6, ST_RTYPE_WB = 7, ST_BEQ_EX = 8,
                   ST_ADDI_EX = 9, ST_IMM_WB = 10, ST_J_EX = 11, ST_LOGI_EX = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    opcode = 6'd0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg;
    logic          alusrc_a, ext_sel, illegal;
    logic [1:0]    alusrc_b, alu_op, pc_src;
    logic [3:0]    state;
    logic [CW-1:0] instr_cnt;
    logic [15:0]   obs_ctrl;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    bit ill_pending = 1'b0;
    int q_st[$];
    bit q_rdy[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alusrc_a(alusrc_a),
        .alusrc_b(alusrc_b), .alu_op(alu_op), .pc_src(pc_src), .ext_sel(ext_sel),
        .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
    );

    assign obs_ctrl = {mem_req, mem_we, iord, ir_we, pc_we, reg_we, reg_dst, mem_to_reg,
                       alusrc_a, alusrc_b, alu_op, pc_src, ext_sel};

    function automatic bit op_legal(input logic [5:0] op);
        case (op)
            6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef LOGIC_IMM_EN
            6'b001100, 6'b001101: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Control word the datapath should see in each step of an instruction.
    function automatic logic [15:0] exp_ctrl(input int st, input bit rdy, input bit z);
        logic mreq, mwe, ia, irw, pcw, rw, rd, m2r, asa, ext;
        logic [1:0] asb, aop, pcs;
        {mreq, mwe, ia, irw, pcw, rw, rd, m2r, asa, ext} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (st)
            ST_FETCH:    begin mreq = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            ST_DECODE:   asb = 2'b11;
            ST_MEMADR:   begin asa = 1; asb = 2'b10; end
            ST_MEMRD:    begin mreq = 1; ia = 1; end
            ST_MEMWB:    begin rw = 1; m2r = 1; end
            ST_MEMWR:    begin mreq = 1; mwe = 1; ia = 1; end
            ST_RTYPE_EX: begin asa = 1; aop = 2'b10; end
            ST_RTYPE_WB: begin rw = 1; rd = 1; end
            ST_BEQ_EX:   begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = z; end
            ST_ADDI_EX:  begin asa = 1; asb = 2'b10; end
            ST_IMM_WB:   rw = 1;
            ST_J_EX:     begin pcs = 2'b10; pcw = 1; end
            ST_LOGI_EX:  begin asa = 1; asb = 2'b10; ext = 1; aop = 2'b11; end
            default: ;
        endcase
        return {mreq, mwe, ia, irw, pcw, rw, rd, m2r, asa, asb, aop, pcs, ext};
    endfunction

    task automatic push_step(input int st, input bit rdy);
        q_st.push_back(st);
        q_rdy.push_back(rdy);
    endtask

    task automatic push_mem(input int st, input int waits);
        repeat (waits) push_step(st, 1'b0);
        push_step(st, 1'b1);
    endtask

    // Walks the queued steps one clock each, checking every cycle.
    task automatic drive_path(input logic [5:0] op, input bit z);
        bit zv;
        for (int i = 0; i < q_st.size(); i++) begin
            @(negedge clk);
            opcode    = (q_st[i] == ST_FETCH) ? 6'($urandom) : op;
            zv        = (q_st[i] == ST_BEQ_EX) ? z : 1'($urandom);
            zero      = zv;
            mem_ready = q_rdy[i];
            #1;
            n_checks++;
            if (state !== 4'(q_st[i])) begin
                n_fail++;
                $display("FAIL state op=%b step%0d: got %0d want %0d", op, i, state, q_st[i]);
            end
            n_checks++;
            if (obs_ctrl !== exp_ctrl(q_st[i], q_rdy[i], zv)) begin
                n_fail++;
                $display("FAIL ctrl op=%b step%0d st=%0d: got %h want %h", op, i, q_st[i],
                         obs_ctrl, exp_ctrl(q_st[i], q_rdy[i], zv));
            end
            n_checks++;
            if (illegal !== ((i == 0) ? ill_pending : 1'b0)) begin
                n_fail++;
                $display("FAIL illegal op=%b step%0d: got %b want %b", op, i, illegal,
                         (i == 0) ? ill_pending : 1'b0);
            end
            if (i == 0) ill_pending = 1'b0;
            n_checks++;
            if (instr_cnt !== CW'(model_cnt)) begin
                n_fail++;
                $display("FAIL instr_cnt op=%b step%0d: got %0d want %0d", op, i, instr_cnt,
                         model_cnt);
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input bit z, input int fw, input int mw);
        q_st.delete();
        q_rdy.delete();
        push_mem(ST_FETCH, fw);
        push_step(ST_DECODE, 1'($urandom));
        if (op_legal(op)) begin
            case (op)
                6'b100011: begin
                    push_step(ST_MEMADR, 1'($urandom));
                    push_mem(ST_MEMRD, mw);
                    push_step(ST_MEMWB, 1'($urandom));
                end
                6'b101011: begin
                    push_step(ST_MEMADR, 1'($urandom));
                    push_mem(ST_MEMWR, mw);
                end
                6'b000000: begin
                    push_step(ST_RTYPE_EX, 1'($urandom));
                    push_step(ST_RTYPE_WB, 1'($urandom));
                end
                6'b000100: push_step(ST_BEQ_EX, 1'($urandom));
                6'b001000: begin
                    push_step(ST_ADDI_EX, 1'($urandom));
                    push_step(ST_IMM_WB, 1'($urandom));
                end
                6'b000010: push_step(ST_J_EX, 1'($urandom));
                default: begin
                    push_step(ST_LOGI_EX, 1'($urandom));
                    push_step(ST_IMM_WB, 1'($urandom));
                end
            endcase
        end
        drive_path(op, z);
        if (op_legal(op)) model_cnt = (model_cnt + 1) % (1 << CW);
        else ill_pending = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_req !== 1'b0 || ir_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: state=%0d mem_req=%b ir_we=%b want 0/0/0", state, mem_req, ir_we);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (instr_cnt !== '0 || illegal !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: cnt=%0d illegal=%b mem_req=%b want 0/0/0", instr_cnt, illegal, mem_req);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL first_fetch: state=%0d mem_req=%b want 0/1", state, mem_req);
        end
        model_cnt = 0;
        ill_pending = 1'b0;
    endtask

    task automatic test_rtype;
        run_instr(6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_lw_wait;
        run_instr(6'b100011, 1'b0, 0, 2);
        run_instr(6'b101011, 1'b0, 1, 1);
    endtask

    task automatic test_beq;
        run_instr(6'b000100, 1'b1, 0, 0);
        run_instr(6'b000100, 1'b0, 1, 0);
        run_instr(6'b000010, 1'b0, 0, 0);
        run_instr(6'b001000, 1'b0, 0, 0);
    endtask

    task automatic test_logic_imm;
        run_instr(6'b001101, 1'b0, 0, 0);
        run_instr(6'b001100, 1'b0, 1, 0);
        run_instr(6'b000000, 1'b0, 0, 0);
    endtask

    task automatic test_illegal;
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(6'b000000, 1'b0, 1, 0);
    endtask

    task automatic test_back_to_back;
        logic [5:0] pool [8];
        logic [5:0] op;
        pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                 6'b001000, 6'b000010, 6'b001100, 6'b001101};
        for (int n = 0; n < 40; n++) begin
            op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : pool[$urandom_range(0, 7)];
            run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_in_memwr;
        q_st.delete();
        q_rdy.delete();
        push_step(ST_FETCH, 1'b1);
        push_step(ST_DECODE, 1'b0);
        push_step(ST_MEMADR, 1'b0);
        push_step(ST_MEMWR, 1'b0);
        push_step(ST_MEMWR, 1'b0);
        drive_path(6'b101011, 1'b0);
        #1;
        mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_req !== 1'b0 || instr_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_memwr: state=%0d mem_req=%b cnt=%0d want 0/0/0", state, mem_req, instr_cnt);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_req !== 1'b0 || pc_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_memwr_hold: state=%0d mem_req=%b pc_we=%b want 0/0/0", state, mem_req, pc_we);
        end
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 4'd0 || mem_req !== 1'b1 || iord !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_memwr_release: state=%0d mem_req=%b iord=%b want 0/1/0", state, mem_req, iord);
        end
        model_cnt = 0;
        ill_pending = 1'b0;
        run_instr(6'b000000, 1'b0, 0, 0);
        run_instr(6'b100011, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_logic_imm();
        test_illegal();
        test_back_to_back();
        test_reset_in_memwr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control FSM for the multi-cycle MIPS datapath. It sequences instruction fetch, decode, execute, memory access and write-back over several cycles per instruction, and drives every datapath mux and write enable. That includes the immediate-extension mode fed to the 16-to-32-bit extender. Memory accesses use a request/ready handshake, so the FSM stalls on slow memory.

## Interface
Parameters:
- `CNT_W`, 32: width of retired-instruction counter.

Ports (clock is `clk`, reset is `reset`, asynchronous active-high):
- `clk` in 1: system clock.
- `reset` in 1: async active-high reset.
- `opcode` in 6: IR[31:26].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access requested.
- `mem_we` out 1: request is a write.
- `iord` out 1: address source (0=PC, 1=ALUOut).
- `ir_we` out 1: load instruction register.
- `pc_we` out 1: PC write (unconditional or branch-taken).
- `reg_we` out 1: register file write.
- `reg_dst` out 1: write-register select (0=rt, 1=rd).
- `mem_to_reg` out 1: write-data select (0=ALUOut, 1=MDR).
- `alusrc_a` out 1: ALU A select (0=PC, 1=rs).
- `alusrc_b` out 2: ALU B select (00=rt, 01=4, 10=ext imm, 11=ext imm<<2).
- `alu_op` out 2: 00=add, 01=sub, 10=funct, 11=logic-imm (funct from opcode).
- `pc_src` out 2: 00=ALU, 01=ALUOut, 10=jump target.
- `ext_sel` out 1: extender mode (0=sign, 1=zero).
- `illegal` out 1: one-cycle pulse on undecodable opcode.
- `state` out 4: current state, for debug.
- `instr_cnt` out CNT_W: retired instructions.

## Operation
- States (4-bit): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE_EX=6, RTYPE_WB=7, BEQ_EX=8, ADDI_EX=9, IMM_WB=10, J_EX=11, LOGI_EX=12.
- FETCH:
  - Drives mem_req=1, iord=0, alusrc_a=0, alusrc_b=01, alu_op=00, pc_src=00.
  - ir_we and pc_we are high only in the cycle mem_ready=1; that cycle moves to DECODE. Otherwise the FSM holds.
- DECODE:
  - alusrc_b=11, alu_op=00, ext_sel=0 (branch target precompute).
  - Next state by opcode:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 → RTYPE_EX.
    - 000100 → BEQ_EX.
    - 001000 → ADDI_EX.
    - 000010 → J_EX.
    - 001100 or 001101 → LOGI_EX (macro-gated).
    - Anything else → FETCH with illegal=1.
- MEMADR: alusrc_a=1, alusrc_b=10, ext_sel=0, alu_op=00. lw → MEMRD; sw → MEMWR.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then → MEMWB.
- MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1 → FETCH.
- MEMWR: mem_req=1, mem_we=1, iord=1. Holds until mem_ready, then → FETCH.
- RTYPE_EX: alusrc_a=1, alusrc_b=00, alu_op=10 → RTYPE_WB.
- RTYPE_WB: reg_we=1, reg_dst=1, mem_to_reg=0 → FETCH.
- BEQ_EX: alusrc_a=1, alusrc_b=00, alu_op=01, pc_src=01, pc_we=zero → FETCH.
- ADDI_EX: alusrc_a=1, alusrc_b=10, ext_sel=0, alu_op=00 → IMM_WB.
- LOGI_EX: alusrc_a=1, alusrc_b=10, ext_sel=1, alu_op=11 → IMM_WB.
- IMM_WB: reg_we=1, reg_dst=0, mem_to_reg=0 → FETCH.
- J_EX: pc_src=10, pc_we=1 → FETCH.
- Any output not listed for a state is 0.
- instr_cnt increments by 1 on every transition into FETCH from a state other than FETCH, excluding the illegal path. It wraps modulo 2^CNT_W.

## Timing
- Outputs are decoded combinationally from the state register (Moore). The exceptions are Mealy terms on mem_ready (ir_we, pc_we in FETCH) and on zero (pc_we in BEQ_EX).
- Reset, async: state=FETCH, instr_cnt=0, illegal=0.
  - mem_req is forced to 0 while reset is high, so no fetch is issued during reset.
  - The first fetch request appears in the first cycle after deassertion.
- Cycles per instruction with zero-wait memory (mem_ready high on first request cycle):
  - lw: 5.
  - sw, R-type, addi, andi/ori: 4.
  - beq, j: 3.
  - Each wait cycle adds 1 per memory state.
- mem_req and the address selection stay stable while waiting. mem_ready when mem_req=0 is ignored.
- Reset mid-instruction: the FSM returns to FETCH immediately. A pending memory request is dropped and the counter clears.

## Configuration
- `LOGIC_IMM_EN` defined:
  - andi/ori decode to LOGI_EX.
  - ext_sel=1 is driven there.
- `LOGIC_IMM_EN` undefined:
  - LOGI_EX is absent; opcodes 001100 and 001101 are illegal.
  - ext_sel is tied to 0, so the extender only sign-extends.

## Structure
- Package `mips_ctrl_pkg`:
  - State encodings.
  - Opcode constants.
  - alusrc_b, alu_op and pc_src encodings.
- Sub-module `mips_ctrl_decode`: combinational state→output decoder. The FSM register, next-state logic and counter stay in the top module.

## Test plan
- Reset deassert, mem_ready=1, opcode=000000 → states 0,1,6,7,0. reg_dst=1 and reg_we=1 in state 7. instr_cnt=1.
- lw (100011) with mem_ready low for 2 cycles in MEMRD → MEMRD lasts 3 cycles with iord=1 and mem_req=1. MEMWB has mem_to_reg=1. Total 7 cycles.
- beq (000100): zero=1 → pc_we=1 in BEQ_EX with pc_src=01. zero=0 → pc_we=0.
- ori (001101) with macro defined → ext_sel=1 in LOGI_EX, alu_op=11. Without macro → illegal pulse, back to FETCH, instr_cnt unchanged.
- opcode=111111 → illegal=1 for exactly one cycle; next state FETCH.
- Assert reset in MEMWR while waiting → state=0, mem_req=0 during reset, instr_cnt=0.
